// File: rtl/down_timer.sv
// Programmable down-counter/timer: one-shot timeout or periodic divide-by-N tick.
// state | meaning: IDLE | parked, count held | RUN | decrementing on en | DONE | one-shot expired
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= ZERO;
      reload <= ZERO;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (stop) begin
        state <= IDLE;
        count <= ZERO;
      end else if (start && (load_val != ZERO)) begin
        reload <= load_val;
        count  <= load_val;
        state  <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (en) begin
              if (count == ONE) begin
                tc <= 1'b1;
                if (auto_reload) begin
                  count <= reload;
                end else begin
                  count <= ZERO;
                  state <= DONE;
                end
              end else if (count > ONE) begin
                count <= count - ONE;
              end
            end
          end
          DONE:    count <= ZERO;
          default: count <= count;
        endcase
      end
    end
  end

  // Decoded from the state flop only, so no input reaches these outputs combinationally.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: vector table, directed corner sequences, randomized run vs model.
module tb_down_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst, start, stop, en, auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, done, tc;

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start), .stop(stop),
    .en(en), .auto_reload(auto_reload), .count(count), .busy(busy),
    .done(done), .tc(tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = expired one-shot
  int m_mode = 0, m_count = 0, m_reload = 0, m_tc = 0;

  task automatic model_step();
    m_tc = 0;
    if (rst) begin
      m_mode = 0; m_count = 0; m_reload = 0;
    end else if (stop) begin
      m_mode = 0; m_count = 0;
    end else if (start && load_val != 0) begin
      m_mode = 1; m_count = int'(load_val); m_reload = int'(load_val);
    end else if (m_mode == 1 && en) begin
      if (m_count == 1) begin
        m_tc = 1;
        if (auto_reload) m_count = m_reload;
        else begin m_count = 0; m_mode = 2; end
      end else if (m_count > 1) begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, int'(count), m_count);
    chk({tag, "_busy"},  int'(busy),  (m_mode == 1) ? 1 : 0);
    chk({tag, "_done"},  int'(done),  (m_mode == 2) ? 1 : 0);
    chk({tag, "_tc"},    int'(tc),    m_tc);
  endtask

  task automatic drive(input bit r, input bit s, input bit p, input bit e,
                       input bit a, input int lv);
    rst = r; start = s; stop = p; en = e; auto_reload = a; load_val = W'(lv);
  endtask

  typedef struct {
    bit r, s, p, e, a;
    int lv;
    int x_count;
    bit x_busy, x_done, x_tc;
  } vec_t;

  vec_t vt[24];

  initial begin
    int first_tc, paused, ntc;
    drive(1, 0, 0, 0, 0, 0);

    //        r  s  p  e  a  lv   cnt b  d  tc
    vt[0]  = '{1, 1, 0, 1, 0, 5,   0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 1, 0, 5,   0, 0, 0, 0};
    vt[2]  = '{0, 1, 0, 1, 0, 5,   5, 1, 0, 0};
    vt[3]  = '{0, 0, 0, 1, 0, 0,   4, 1, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 0, 0,   3, 1, 0, 0};
    vt[5]  = '{0, 0, 0, 1, 0, 0,   2, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 0, 0,   1, 1, 0, 0};
    vt[7]  = '{0, 0, 0, 1, 0, 0,   0, 0, 1, 1};
    vt[8]  = '{0, 0, 0, 1, 0, 0,   0, 0, 1, 0};
    vt[9]  = '{0, 1, 0, 1, 0, 0,   0, 0, 1, 0};
    vt[10] = '{0, 0, 1, 1, 0, 0,   0, 0, 0, 0};
    vt[11] = '{0, 1, 0, 1, 0, 0,   0, 0, 0, 0};
    vt[12] = '{0, 1, 0, 1, 1, 3,   3, 1, 0, 0};
    vt[13] = '{0, 0, 0, 1, 1, 0,   2, 1, 0, 0};
    vt[14] = '{0, 0, 0, 1, 1, 0,   1, 1, 0, 0};
    vt[15] = '{0, 0, 0, 1, 1, 0,   3, 1, 0, 1};
    vt[16] = '{0, 0, 0, 1, 1, 0,   2, 1, 0, 0};
    vt[17] = '{0, 0, 0, 1, 1, 0,   1, 1, 0, 0};
    vt[18] = '{0, 1, 1, 1, 1, 7,   0, 0, 0, 0};
    vt[19] = '{0, 1, 0, 1, 0, 2,   2, 1, 0, 0};
    vt[20] = '{0, 0, 0, 1, 0, 0,   1, 1, 0, 0};
    vt[21] = '{0, 1, 0, 1, 0, 6,   6, 1, 0, 0};
    vt[22] = '{0, 0, 0, 0, 0, 0,   6, 1, 0, 0};
    vt[23] = '{0, 0, 1, 0, 0, 0,   0, 0, 0, 0};

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].r, vt[i].s, vt[i].p, vt[i].e, vt[i].a, vt[i].lv);
      edge_step();
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].x_count);
      chk($sformatf("vec%0d_busy", i),  int'(busy),  int'(vt[i].x_busy));
      chk($sformatf("vec%0d_done", i),  int'(done),  int'(vt[i].x_done));
      chk($sformatf("vec%0d_tc", i),    int'(tc),    int'(vt[i].x_tc));
    end

    // One-shot of 5 then DONE must hold count 0 for 10 more cycles
    drive(0, 1, 0, 1, 0, 5);
    edge_step();
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) edge_step();
    chk("oneshot_tc", int'(tc), 1);
    for (int i = 0; i < 10; i++) begin
      edge_step();
      chk("oneshot_hold_count", int'(count), 0);
      chk("oneshot_hold_done", int'(done), 1);
    end

    // Periodic load 3: count 2,1,3,... with tc on each reload
    drive(0, 1, 0, 1, 1, 3);
    edge_step();
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      edge_step();
      chk("per3_count", int'(count), 3 - (i % 3));
      chk("per3_tc", int'(tc), (i % 3 == 0) ? 1 : 0);
    end

    // Periodic load 15: exactly one tc per 15 cycles
    drive(0, 1, 0, 1, 1, 15);
    edge_step();
    drive(0, 0, 0, 1, 1, 0);
    ntc = 0;
    for (int i = 1; i <= 60; i++) begin
      edge_step();
      chk_model("per15");
      if (tc) begin
        ntc++;
        chk("per15_tc_pos", i % 15, 0);
      end
    end
    chk("per15_tc_count", ntc, 4);

    // Enable gating: pause 3 cycles at count 2, tc lands 3 cycles late
    drive(0, 1, 1, 0, 0, 0);
    edge_step();
    drive(0, 1, 0, 1, 0, 4);
    edge_step();
    drive(0, 0, 0, 1, 0, 0);
    first_tc = 0; paused = 0;
    for (int i = 1; i <= 20; i++) begin
      if (count == 2 && paused < 3) begin en = 1'b0; paused++; end
      else en = 1'b1;
      edge_step();
      chk_model("gate");
      if (tc && first_tc == 0) first_tc = i;
    end
    chk("gate_tc_delay", first_tc, 7);

    // Stop at count 2
    drive(0, 1, 0, 1, 0, 5);
    edge_step();
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) edge_step();
    chk("pre_stop_count", int'(count), 2);
    stop = 1'b1;
    edge_step();
    chk("stop_count", int'(count), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_tc", int'(tc), 0);

    // Restart with 9 while running at 6
    drive(0, 1, 0, 1, 0, 8);
    edge_step();
    drive(0, 0, 0, 1, 0, 0);
    edge_step();
    edge_step();
    chk("pre_restart_count", int'(count), 6);
    drive(0, 1, 0, 1, 0, 9);
    edge_step();
    chk("restart_count", int'(count), 9);

    // Reset mid-run with start held is ignored
    drive(0, 1, 0, 1, 1, 10);
    edge_step();
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) edge_step();
    drive(1, 1, 0, 1, 1, 10);
    edge_step();
    edge_step();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tc", int'(tc), 0);

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      stop        = ($urandom_range(0, 99) < 5);
      start       = ($urandom_range(0, 99) < 12);
      en          = ($urandom_range(0, 99) < 80);
      auto_reload = $urandom_range(0, 1);
      if (m_mode == 1) load_val = W'($urandom_range(1, 15));
      else             load_val = W'($urandom_range(0, 15));
      edge_step();
      chk_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
